// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD subtraction controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_RADIX = 4'd10;
    localparam bcd_digit_t BCD_MAX   = 4'd9;

    function automatic logic is_bcd(input bcd_digit_t v);
        return (v <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_sub_seq_if.sv
// Operand/result handshake bundle between operand decode, the subtractor and the result mux.
interface bcd_sub_seq_if #(parameter int DIGITS = 8);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   x;
    logic [4*DIGITS-1:0]   y;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   diff;
    logic                  borrow;
    logic                  err;
    logic                  busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, diff, borrow, err, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, diff, borrow, err, busy
    );

endinterface

// File: rtl/bcd_digit_sub.sv
// Single combinational BCD digit subtractor: d = a - b - bin, wrapped into 0..9 with borrow out.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout,
    output logic       bad
);

    logic [4:0] t_s;

    // Five-bit signed difference; bit 4 set means the raw result went negative.
    always_comb begin
        t_s  = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        bad  = !is_bcd(a) || !is_bcd(b);
        bout = t_s[4];
        if (t_s[4]) begin
            d = t_s[3:0] + BCD_RADIX;
        end else begin
            d = t_s[3:0];
        end
    end

endmodule

// File: rtl/bcd_sub_seq.sv
// Digit-serial BCD subtraction controller: x - y one digit per cycle, LSD first, one shared digit stage.
module bcd_sub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8
)(
    input  logic          clk,
    input  logic          rst,
    bcd_sub_seq_if.slave  bus
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state_q, state_d;
    logic [W-1:0]       x_q, x_d, y_q, y_d, diff_q, diff_d;
    logic               b_q, b_d, borrow_q, borrow_d, err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    bcd_digit_t         xa_s, yb_s, d_s;
    logic               bout_s, bad_s, err_all_s;

    assign xa_s = x_q[{idx_q, 2'b00} +: 4];
    assign yb_s = y_q[{idx_q, 2'b00} +: 4];

    bcd_digit_sub u_digit (
        .a    (xa_s),
        .b    (yb_s),
        .bin  (b_q),
        .d    (d_s),
        .bout (bout_s),
        .bad  (bad_s)
    );

    assign err_all_s = err_q | bad_s;

    // Next-state and datapath update for IDLE/RUN/DONE.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        diff_d   = diff_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        err_d    = err_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d      = bus.x;
                    y_d      = bus.y;
                    diff_d   = '0;
                    b_d      = 1'b0;
                    borrow_d = 1'b0;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                diff_d[{idx_q, 2'b00} +: 4] = d_s;
                b_d   = bout_s;
                err_d = err_all_s;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    state_d = DONE;
                    // A bad nibble anywhere makes the numeric result meaningless.
                    if (err_all_s) begin
                        diff_d   = '0;
                        borrow_d = 1'b0;
                    end else begin
                        borrow_d = bout_s;
                    end
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            diff_q   <= '0;
            b_q      <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            diff_q   <= diff_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Directed self-checking bench for bcd_sub_seq with DIGITS=4.
module tb_bcd_sub_seq;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    int   n;

    bcd_sub_seq_if #(.DIGITS(4)) bus ();

    bcd_sub_seq #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] xv, input logic [15:0] yv);
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        tick();
        bus.in_valid = 1'b0;
        bus.x        = 16'h0000;
        bus.y        = 16'h0000;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("ret_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ret_in_ready",  {31'd0, bus.in_ready},  32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic [15:0] ed, input logic eb, input logic ee);
        accept(xv, yv);
        chk({tag, "_busy"},     {31'd0, bus.busy},     32'd1);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        wait_done(n);
        chk({tag, "_latency"}, n, 32'd4);
        chk({tag, "_diff"},    {16'd0, bus.diff}, {16'd0, ed});
        chk({tag, "_borrow"},  {31'd0, bus.borrow}, {31'd0, eb});
        chk({tag, "_err"},     {31'd0, bus.err},    {31'd0, ee});
        release_result();
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = 16'h0000;
        bus.y         = 16'h0000;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_diff",      {16'd0, bus.diff},      32'd0);
        chk("rst_borrow",    {31'd0, bus.borrow},    32'd0);
        chk("rst_err",       {31'd0, bus.err},       32'd0);
        chk("rst_busy",      {31'd0, bus.busy},      32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        run_op("basic", 16'h4321, 16'h1234, 16'h3087, 1'b0, 1'b0);
        run_op("neg",   16'h0100, 16'h0123, 16'h9977, 1'b1, 1'b0);
        run_op("wrap",  16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0);
        run_op("equal", 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0);
        run_op("bad",   16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1);

        // New operands offered during RUN must be ignored; then hold the result under backpressure.
        accept(16'h8000, 16'h0001);
        bus.in_valid = 1'b1;
        bus.x        = 16'h1111;
        bus.y        = 16'h0000;
        wait_done(n);
        bus.in_valid = 1'b0;
        chk("bp_latency", n, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_diff",      {16'd0, bus.diff},       32'h7999);
            chk("bp_borrow",    {31'd0, bus.borrow},     32'd0);
            chk("bp_err",       {31'd0, bus.err},        32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid},  32'd1);
            chk("bp_in_ready",  {31'd0, bus.in_ready},   32'd0);
            tick();
        end
        release_result();
        tick();
        chk("bp_no_accept", {31'd0, bus.busy}, 32'd0);

        // Reset in the second RUN cycle aborts the operation.
        accept(16'h4321, 16'h1234);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_diff",      {16'd0, bus.diff},      32'd0);
        chk("mid_rst_busy",      {31'd0, bus.busy},      32'd0);
        chk("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        run_op("after_rst", 16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0);

        // Reset wins over a simultaneous request.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.x        = 16'h0009;
        bus.y        = 16'h0001;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("rst_vs_valid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_vs_valid_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
